// File: rtl/elbeth_md_pkg.sv
// Shared types and constants for the ELBETH iterative multiply/divide unit.
package elbeth_md_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned MD_ITERATIONS = 32;
  localparam int unsigned MD_CNT_W      = 6;

  localparam logic [31:0] MD_DIV_ZERO_Q = 32'hFFFFFFFF;
  localparam logic [31:0] MD_INT_MIN    = 32'h80000000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

  // Two's-complement magnitude when the value is to be treated as negative.
  function automatic logic [31:0] md_abs(input logic [31:0] v, input logic neg);
    return neg ? 32'(-v) : v;
  endfunction

endpackage

// File: rtl/elbeth_md_div_core.sv
// Restoring divider step register: one shift-subtract step per enable.
// Only built when ELBETH_MUL_DIV_DIVIDER_EN is defined.
`ifdef ELBETH_MUL_DIV_DIVIDER_EN
module elbeth_md_div_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;
  logic            borrow;

  // Shift the next dividend bit in and trial-subtract; borrow means restore.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {2'b00, dvs_q};
  assign borrow  = diff[XLEN+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= borrow ? shifted[XLEN:0] : diff[XLEN:0];
      quo_q <= {quo_q[XLEN-2:0], ~borrow};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q[XLEN-1:0];

endmodule
`endif

// File: rtl/elbeth_mul_div.sv
// Iterative RISC-V M-extension multiply/divide unit (32 cycles per op).
// Divider datapath is present only when ELBETH_MUL_DIV_DIVIDER_EN is defined.
module elbeth_mul_div #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            md_start,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] md_operand_a,
  input  logic [XLEN-1:0] md_operand_b,
  input  logic            md_abort,
  output logic            md_busy,
  output logic            md_ready,
  output logic [XLEN-1:0] md_result
);

  import elbeth_md_pkg::*;

  md_state_t         state;
  md_op_t            op_q;
  logic [MD_CNT_W-1:0] cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mcand;
  logic              neg_res;

  md_op_t            start_op;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   mul_word;
  logic [XLEN-1:0]   fix_word;
  logic              accept;

  assign start_op = md_op_t'(md_op);
  assign accept   = (state == MD_IDLE) && md_start && !md_abort;

  // Operand signedness per funct3; unsigned ops and MUL low word never negate.
  assign a_signed = (start_op == OP_MULH) || (start_op == OP_MULHSU) ||
                    (start_op == OP_DIV)  || (start_op == OP_REM);
  assign b_signed = (start_op == OP_MULH) || (start_op == OP_DIV) ||
                    (start_op == OP_REM);
  assign a_neg    = a_signed && md_operand_a[XLEN-1];
  assign b_neg    = b_signed && md_operand_b[XLEN-1];
  assign mag_a    = md_abs(md_operand_a, a_neg);
  assign mag_b    = md_abs(md_operand_b, b_neg);

  // Radix-2 shift-add step: multiplier sits in the low half of acc.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mcand : XLEN'(0))};
  assign prod_fix = neg_res ? (2*XLEN)'(-acc) : acc;
  assign mul_word = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

`ifdef ELBETH_MUL_DIV_DIVIDER_EN
  logic            neg_rem;
  logic            start_div;
  logic            b_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_val;
  logic [XLEN-1:0] div_quo, div_rem;
  logic [XLEN-1:0] q_fix, r_fix;
  logic            div_load, div_step;

  assign start_div = md_op[2];
  assign b_zero    = (md_operand_b == '0);
  assign div_ovf   = ((start_op == OP_DIV) || (start_op == OP_REM)) &&
                     (md_operand_a == MD_INT_MIN) && (md_operand_b == '1);
  assign special   = start_div && (b_zero || div_ovf);
  // md_op[1] selects the remainder flavour of a divide.
  assign special_val = md_op[1] ? (b_zero ? md_operand_a : XLEN'(0))
                                : (b_zero ? MD_DIV_ZERO_Q : MD_INT_MIN);

  assign div_load = accept && start_div && !special;
  assign div_step = (state == MD_CALC) && op_q[2];

  elbeth_md_div_core #(.XLEN(XLEN)) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .step      (div_step),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign q_fix    = neg_res ? XLEN'(-div_quo) : div_quo;
  assign r_fix    = neg_rem ? XLEN'(-div_rem) : div_rem;
  assign fix_word = op_q[2] ? (op_q[1] ? r_fix : q_fix) : mul_word;
`else
  assign fix_word = mul_word;
`endif

  // Sequencer: abort has priority over everything except reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MD_IDLE;
      op_q      <= OP_MUL;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      neg_res   <= 1'b0;
`ifdef ELBETH_MUL_DIV_DIVIDER_EN
      neg_rem   <= 1'b0;
`endif
      md_busy   <= 1'b0;
      md_ready  <= 1'b0;
      md_result <= '0;
    end else if (md_abort) begin
      state    <= MD_IDLE;
      md_busy  <= 1'b0;
      md_ready <= 1'b0;
    end else begin
      md_ready <= 1'b0;
      unique case (state)
        MD_IDLE: begin
          if (md_start) begin
            op_q    <= start_op;
            cnt     <= '0;
            md_busy <= 1'b1;
            acc     <= {XLEN'(0), mag_b};
            mcand   <= mag_a;
            neg_res <= a_neg ^ b_neg;
            if (md_op[2]) begin
`ifdef ELBETH_MUL_DIV_DIVIDER_EN
              neg_rem <= a_neg;
              if (special) begin
                md_result <= special_val;
                md_ready  <= 1'b1;
                state     <= MD_DONE;
              end else begin
                state <= MD_CALC;
              end
`else
              md_result <= '0;
              md_ready  <= 1'b1;
              state     <= MD_DONE;
`endif
            end else begin
              state <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          cnt <= cnt + MD_CNT_W'(1);
          acc <= {mul_sum, acc[XLEN-1:1]};
          if (cnt == MD_CNT_W'(MD_ITERATIONS - 1)) begin
            state <= MD_FIX;
          end
        end
        MD_FIX: begin
          md_result <= fix_word;
          md_ready  <= 1'b1;
          state     <= MD_DONE;
        end
        MD_DONE: begin
          md_busy <= 1'b0;
          state   <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elbeth_mul_div.sv
// Directed self-checking bench for elbeth_mul_div (both divider build options).
module tb_elbeth_mul_div;

`ifdef ELBETH_MUL_DIV_DIVIDER_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        md_start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] md_operand_a = '0;
  logic [31:0] md_operand_b = '0;
  logic        md_abort = 1'b0;
  logic        md_busy;
  logic        md_ready;
  logic [31:0] md_result;

  int total = 0;
  int bad   = 0;

  elbeth_mul_div #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .md_start     (md_start),
    .md_op        (md_op),
    .md_operand_a (md_operand_a),
    .md_operand_b (md_operand_b),
    .md_abort     (md_abort),
    .md_busy      (md_busy),
    .md_ready     (md_ready),
    .md_result    (md_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op and wait for md_ready; lat counts negedges after the accepting edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] oa, input logic [31:0] ob,
                        input int inject_at, output logic [31:0] res, output int lat,
                        output logic busy_all);
    @(negedge clk);
    md_op = op; md_operand_a = oa; md_operand_b = ob; md_start = 1'b1;
    lat = -1;
    busy_all = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == inject_at) begin
        md_start = 1'b1; md_op = 3'd3; md_operand_a = '1; md_operand_b = '1;
      end else begin
        md_start = 1'b0;
      end
      busy_all = busy_all & md_busy;
      if (md_ready) begin
        lat = i;
        break;
      end
    end
    md_start = 1'b0;
    res = md_result;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [0:14] = '{
    '{3'd0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 34},
    '{3'd1, 32'h80000000,  32'h80000000, 32'h40000000, 34},
    '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 34},
    '{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 34},
    '{3'd0, 32'h12345678,  32'h00000010, 32'h23456780, 34},
    '{3'd1, 32'hFFFFFFFD,  32'd7,        32'hFFFFFFFF, 34},
    '{3'd4, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 34},
    '{3'd6, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 34},
    '{3'd5, 32'd100,       32'd7,        32'd14,       34},
    '{3'd7, 32'd100,       32'd7,        32'd2,        34},
    '{3'd5, 32'd5,         32'd0,        32'hFFFFFFFF, 1},
    '{3'd6, 32'h80000000,  32'hFFFFFFFF, 32'd0,        1},
    '{3'd4, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1},
    '{3'd7, 32'd5,         32'd0,        32'd5,        1},
    '{3'd6, 32'd7,         32'hFFFFFFFE, 32'd1,        34}
  };

  logic [31:0] res;
  logic [31:0] prev;
  logic        busy_all;
  int          lat;
  int          pulses;
  logic [31:0] exp_r;
  int          exp_l;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(md_busy),  32'd0);
    check("rst_ready",  32'(md_ready), 32'd0);
    check("rst_result", md_result,     32'd0);
    rst = 1'b0;

    // Directed vector table; divides expect 0 with latency 1 when the divider is absent.
    for (int i = 0; i <= 14; i++) begin
      exp_r = (vecs[i].op[2] && !DIV_EN) ? 32'd0 : vecs[i].exp;
      exp_l = (vecs[i].op[2] && !DIV_EN) ? 1 : vecs[i].lat;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, res, lat, busy_all);
      check($sformatf("v%0d_result", i), res, exp_r);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_l));
      check($sformatf("v%0d_busy", i), 32'(busy_all), 32'd1);
      if (i == 0) begin
        @(negedge clk);
        check("post_done_ready", 32'(md_ready), 32'd0);
        check("post_done_busy",  32'(md_busy),  32'd0);
      end
    end
    prev = (DIV_EN) ? 32'd1 : 32'd0;

    // Abort during CALC: back to IDLE, no ready pulse, result retained.
    @(negedge clk);
    md_op = 3'd0; md_operand_a = 32'd3; md_operand_b = 32'd5; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    repeat (9) @(negedge clk);
    md_abort = 1'b1;
    @(negedge clk);
    md_abort = 1'b0;
    check("abort_busy",   32'(md_busy),  32'd0);
    check("abort_ready",  32'(md_ready), 32'd0);
    check("abort_result", md_result,     prev);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (md_ready) pulses++;
    end
    check("abort_no_ready", 32'(pulses), 32'd0);

    // Abort wins over a simultaneous start.
    md_op = 3'd0; md_operand_a = 32'd2; md_operand_b = 32'd2;
    md_start = 1'b1; md_abort = 1'b1;
    @(negedge clk);
    md_start = 1'b0; md_abort = 1'b0;
    check("abort_vs_start_busy", 32'(md_busy), 32'd0);

    // A start pulse while busy is ignored.
    run_op(3'd0, 32'd6, 32'd7, 5, res, lat, busy_all);
    check("ignore_start_result",  res,        32'd42);
    check("ignore_start_latency", 32'(lat),   32'd34);
    @(negedge clk);
    check("ignore_start_idle", 32'(md_busy), 32'd0);

    // Reset mid-CALC clears all outputs on the next cycle.
    @(negedge clk);
    md_op = 3'd0; md_operand_a = 32'd9; md_operand_b = 32'd9; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy",   32'(md_busy),  32'd0);
    check("midrst_ready",  32'(md_ready), 32'd0);
    check("midrst_result", md_result,     32'd0);
    rst = 1'b0;

    run_op(3'd4, 32'd9, 32'd3, 0, res, lat, busy_all);
    check("div9_3_result",  res,      DIV_EN ? 32'd3 : 32'd0);
    check("div9_3_latency", 32'(lat), DIV_EN ? 32'd34 : 32'd1);

    run_op(3'd0, 32'd9, 32'd9, 0, res, lat, busy_all);
    check("mul9_9_result", res, 32'd81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elbeth_mul_div.md
# elbeth_mul_div

Iterative 32-bit multiply/divide unit implementing the RISC-V M-extension operations for the ELBETH core. It sits in the execute stage beside the ALU. Its result feeds the 32-bit 2-to-1 writeback-select mux on the `mux_in_2` side, with the ALU result on `mux_in_1`. The pipeline stalls on `md_busy` and captures the result on `md_ready`.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `clk` input 1: single clock. All state changes occur on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `md_start` input 1: request a new operation. Sampled only in IDLE.
- `md_op` input 3: RISC-V funct3 encoding.
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `md_operand_a` input 32: rs1 value. Captured on the accepting edge.
- `md_operand_b` input 32: rs2 value. Captured on the accepting edge.
- `md_abort` input 1: pipeline flush. Cancels any in-flight operation.
- `md_busy` output 1: high while an operation is in flight. Reset value 0.
- `md_ready` output 1: one-cycle pulse when `md_result` becomes valid. Reset value 0.
- `md_result` output 32: result of the last completed operation. Reset value 0.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE:**
  - If `md_start=1` and `md_abort=0`: latch the operands and op, take operand magnitudes, record the result sign, clear the 6-bit iteration counter, go to CALC.
  - A special-case divide goes straight to DONE instead.
- **CALC:**
  - Performs one iteration per cycle.
  - Multiply: radix-2 shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract on a 33-bit partial remainder plus a 32-bit quotient.
  - After iteration 32 (counter reaches 31), go to FIX.
- **FIX:**
  - Apply two's-complement negation if the recorded sign requires it. Multiply negates the 64-bit product; DIV/REM negate quotient or remainder.
  - Select the output word:
    - MUL: low word.
    - MULH, MULHSU, MULHU: high word.
    - DIV, DIVU: quotient.
    - REM, REMU: remainder.
  - Register the selected word into `md_result` and go to DONE.
- **DONE:** `md_ready=1` for exactly this cycle, then go to IDLE.
- **Sign rules:**
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - Quotient sign is a XOR b; remainder sign follows the dividend.
  - Unsigned ops are never negated.
- **Special cases** (divide only; they skip CALC and FIX):
  - b == 0: quotient 0xFFFFFFFF, remainder = a.
  - DIV/REM with a == 0x80000000 and b == 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- `md_busy = 1` in CALC, FIX and DONE; `md_busy = 0` in IDLE.
- `md_start` while busy is ignored; there is no queuing.
- `md_result` holds its value until the next FIX or special-case load.
- **Abort:**
  - `md_abort=1` in any state forces IDLE on the next edge, with no `md_ready` pulse.
  - `md_result` keeps its previous value.
  - Abort has priority over start in the same cycle.
- `rst` mid-operation forces IDLE, clears the counter and drives all outputs to their reset values.

## Timing
- Start accepted at edge E0; CALC iterations occur on edges E1..E32.
- FIX registers `md_result` at edge E33, which enters DONE.
- `md_ready` is high in the cycle after E33. Normal latency is 34 cycles from the accepting edge to `md_ready`.
- Special-case divides: `md_ready` is high in the cycle after E0 (latency 1).
- The next start can be accepted on the edge that leaves DONE only if it arrives in IDLE; the minimum issue interval is 35 cycles.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- Macro: `ELBETH_MUL_DIV_DIVIDER_EN`.
- **Defined:** full behaviour as above.
- **Undefined:**
  - The divider datapath and special-case logic are not compiled.
  - Ops 4–7 are accepted and complete with latency 1 (DONE in the cycle after E0), with `md_result = 0`.
  - Multiply behaviour is unchanged.

## Structure
- Package `elbeth_md_pkg`:
  - `XLEN` constant.
  - `md_op_t` enum with the eight funct3 codes.
  - `md_state_t` enum (IDLE, CALC, FIX, DONE).
  - Constants `MD_ITERATIONS=32`, `MD_DIV_ZERO_Q=32'hFFFFFFFF`, `MD_INT_MIN=32'h80000000`.
- Sub-module `elbeth_md_div_core`:
  - Holds the restoring-divider step register: partial remainder plus quotient, one step per enable.
  - Instantiated only under `ELBETH_MUL_DIV_DIVIDER_EN`.
- The FSM, multiplier accumulator and sign fix stay in the top module.

## Test plan
- MUL, a=7, b=-3 (0xFFFFFFFD) → `md_result`=0xFFFFFFEB; `md_ready` pulse 34 cycles after the accepting edge; `md_busy` high throughout.
- MULH, a=b=0x80000000 → 0x40000000. MULHU, a=b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU, a=-1, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV, a=-7, b=2 → 0xFFFFFFFD. REM, same operands → 0xFFFFFFFF. DIVU, a=100, b=7 → 14. REMU, same operands → 2.
- DIVU, a=5, b=0 → 0xFFFFFFFF, with latency 1. REM, a=0x80000000, b=-1 → 0, with latency 1.
- Abort at CALC iteration 10 → IDLE next cycle, no `md_ready`, `md_result` unchanged. A `md_start` pulse during `md_busy` → ignored.
- `rst` asserted mid-CALC → next cycle `md_busy`=0, `md_ready`=0, `md_result`=0. With the macro undefined, DIV a=9, b=3 → 0, with latency 1.
